// File: rtl/lsu_memdados.sv
// Load/store unit between the CPU and a word-organised data memory.
// Sub-word stores are done as read-modify-write; lanes are big-endian.
// All memory-side outputs are registered; the memory acts on the negedge.
module lsu_memdados #(
    parameter int ADDR_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        store,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] byte_addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        EscreveMem,
    output logic        LeMem,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] LeituraMemDados
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        DONE
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;
    logic [31:0] r_merge;

    logic        w_illegal;
    logic [31:0] w_word_idx;
    logic        w_unused_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Address bits above the memory index are deliberately dropped (wrap).
    assign w_word_idx    = 32'(byte_addr[ADDR_BITS+1:2]);
    assign w_unused_addr = ^byte_addr[31:ADDR_BITS+2];

    // Illegal size or misaligned address, checked on the live request.
    always_comb begin
        w_illegal = 1'b0;
        case (size)
            2'b01:   w_illegal = byte_addr[0];
            2'b10:   w_illegal = (byte_addr[1:0] != 2'b00);
            2'b11:   w_illegal = 1'b1;
            default: w_illegal = 1'b0;
        endcase
    end

    // Extract and extend the addressed lane of the word coming back from memory.
    always_comb begin
        w_byte = LeituraMemDados[31:24];
        case (r_off)
            2'd0:    w_byte = LeituraMemDados[31:24];
            2'd1:    w_byte = LeituraMemDados[23:16];
            2'd2:    w_byte = LeituraMemDados[15:8];
            default: w_byte = LeituraMemDados[7:0];
        endcase
        w_half = r_off[1] ? LeituraMemDados[15:0] : LeituraMemDados[31:16];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = LeituraMemDados;
        endcase
    end

    // Replace the addressed byte or halfword lane of the captured word.
    always_comb begin
        w_merged = r_merge;
        if (r_size == 2'b00) begin
            case (r_off)
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_off[1]) begin
            w_merged[15:0] = r_wdata;
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    // Access sequencer with registered handshake and memory strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_merge    <= '0;
            ready      <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            EscreveMem <= 1'b0;
            LeMem      <= 1'b0;
            address    <= '0;
            writeData  <= '0;
        end else begin
            done       <= 1'b0;
            EscreveMem <= 1'b0;
            LeMem      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_store    <= store;
                        r_unsigned <= unsigned_ld;
                        r_size     <= size;
                        r_off      <= byte_addr[1:0];
                        r_wdata    <= wdata[15:0];
                        address    <= w_word_idx;
                        ready      <= 1'b0;
                        if (w_illegal) begin
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else if (store && size == 2'b10) begin
                            writeData  <= wdata;
                            EscreveMem <= 1'b1;
                            r_state    <= WRITE;
                        end else begin
                            LeMem   <= 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (r_store) begin
                        r_merge <= LeituraMemDados;
                        r_state <= MERGE;
                    end else begin
                        rdata   <= w_load;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                MERGE: begin
                    writeData  <= w_merged;
                    EscreveMem <= 1'b1;
                    r_state    <= WRITE;
                end
                WRITE: begin
                    err     <= 1'b0;
                    done    <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    err     <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    ready   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_memdados.sv
// Scoreboard bench for lsu_memdados: expected reads, writes and completions
// are queued when an access is issued and popped as the DUT produces them.
module tb_lsu_memdados;

    logic        clk;
    logic        rst;
    logic        req;
    logic        store;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] byte_addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        EscreveMem;
    logic        LeMem;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] LeituraMemDados;

    lsu_memdados #(.ADDR_BITS(5)) dut (
        .clk(clk), .rst(rst), .req(req), .store(store), .size(size),
        .unsigned_ld(unsigned_ld), .byte_addr(byte_addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .EscreveMem(EscreveMem), .LeMem(LeMem), .address(address),
        .writeData(writeData), .LeituraMemDados(LeituraMemDados)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t        q_done[$];
    wr_t         q_wr[$];
    logic [31:0] q_rd[$];

    logic [31:0] mem     [32] = '{default: '0};
    logic [31:0] ref_mem [32] = '{default: '0};
    logic [31:0] last_rdata = '0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acts on the negedge of the cycle the strobes are driven.
    always @(negedge clk) begin
        if (EscreveMem === 1'b1) mem[address[4:0]] = writeData;
        if (LeMem === 1'b1) LeituraMemDados = mem[address[4:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> ((3 - int'(off)) * 8));
        h = 16'(w >> (off[1] ? 0 : 16));
        if (sz == 2'b00) return uns ? {24'b0, b} : {{24{b[7]}}, b};
        if (sz == 2'b01) return uns ? {16'b0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
        int          sh;
        logic [31:0] m;
        if (sz == 2'b00) begin
            sh = (3 - int'(off)) * 8;
            m  = 32'h0000_00FF << sh;
        end else begin
            sh = off[1] ? 0 : 16;
            m  = 32'h0000_FFFF << sh;
        end
        return (w & ~m) | ((wd << sh) & m);
    endfunction

    // Monitor: strobe exclusion every cycle, strobes and completions vs. queues.
    initial begin
        wr_t  w;
        exp_t e;
        forever begin
            @(negedge clk);
            if (EscreveMem === 1'b1 || LeMem === 1'b1)
                check_eq("strobe_excl", 32'(EscreveMem & LeMem), 32'd0);
            if (LeMem === 1'b1) begin
                if (q_rd.size() == 0) check_eq("unexp_read", 32'(LeMem), 32'd0);
                else check_eq("rd_addr", address, q_rd.pop_front());
            end
            if (EscreveMem === 1'b1) begin
                if (q_wr.size() == 0) check_eq("unexp_write", 32'(EscreveMem), 32'd0);
                else begin
                    w = q_wr.pop_front();
                    check_eq("wr_addr", address, w.addr);
                    check_eq("wr_data", writeData, w.data);
                end
            end
            if (done === 1'b1) begin
                if (q_done.size() == 0) check_eq("unexp_done", 32'(done), 32'd0);
                else begin
                    e = q_done.pop_front();
                    check_eq("err", 32'(err), 32'(e.err));
                    check_eq("rdata", rdata, e.rdata);
                    check_eq("latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (ready !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("ready_window", 32'(ready), 32'd1);
    endtask

    // Issue one access, queue its expected effects, wait for completion.
    task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit hold, input bit noise);
        exp_t        e;
        wr_t         w;
        int          k;
        int unsigned lat;
        logic [4:0]  idx;
        logic [31:0] word;
        wait_ready();
        req = 1'b1; store = st; size = sz; unsigned_ld = uns; byte_addr = a; wdata = wd;
        idx  = a[6:2];
        word = ref_mem[idx];
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        if (is_illegal(sz, a)) begin
            lat     = 1;
            e.err   = 1'b1;
            e.rdata = last_rdata;
        end else if (st) begin
            e.err   = 1'b0;
            e.rdata = last_rdata;
            w.addr  = 32'(idx);
            if (sz == 2'b10) begin
                lat    = 2;
                w.data = wd;
            end else begin
                lat    = 4;
                q_rd.push_back(32'(idx));
                w.data = ref_merge(word, wd, sz, a[1:0]);
            end
            q_wr.push_back(w);
            ref_mem[idx] = w.data;
        end else begin
            lat        = 2;
            e.err      = 1'b0;
            e.rdata    = ref_load(word, sz, a[1:0], uns);
            last_rdata = e.rdata;
            q_rd.push_back(32'(idx));
        end
        e.cyc = cyc + lat - 1;
        q_done.push_back(e);
        check_eq("busy_after_accept", 32'(ready), 32'd0);
        if (noise) begin
            req = 1'b1; store = 1'b1; size = 2'b10;
            @(posedge clk); #1;
            req = 1'b0;
        end
        k = 0;
        while (q_done.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("done_timeout", q_done.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; store = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        byte_addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_strobes", {29'b0, done, EscreveMem, LeMem}, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_address", address, 32'd0);
        check_eq("rst_wdata", writeData, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 0, 0);
        do_op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 1);
        do_op(1'b1, 2'b00, 1'b0, 32'h09, 32'h55, 0, 0);
        do_op(1'b0, 2'b00, 1'b0, 32'h09, 32'h0, 0, 0);
        do_op(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, 0, 0);
        do_op(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, 0, 0);
        do_op(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, 0, 0);
        do_op(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, 0, 0);
        do_op(1'b1, 2'b01, 1'b0, 32'h08, 32'h1234, 0, 0);
        do_op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 0);
        check_eq("mem_word2", mem[2], 32'h1234BEEF);
        do_op(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 0, 0);
        do_op(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, 0, 0);
        do_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 0);

        for (int i = 0; i < 30; i++)
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 0, 0);

        // Reset during the MERGE of a byte store: the access must vanish.
        wait_ready();
        req = 1'b1; store = 1'b1; size = 2'b00; unsigned_ld = 1'b0;
        byte_addr = 32'h09; wdata = 32'h77;
        @(posedge clk); #1;
        req = 1'b0;
        q_rd.push_back(32'd2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("abort_ready", 32'(ready), 32'd1);
        check_eq("abort_strobes", {29'b0, done, EscreveMem, LeMem}, 32'd0);
        check_eq("abort_err", 32'(err), 32'd0);
        check_eq("abort_rdata", rdata, 32'd0);
        check_eq("abort_address", address, 32'd0);
        check_eq("abort_wdata", writeData, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_rdata = '0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("abort_pending_wr", q_wr.size(), 32'd0);
        check_eq("abort_pending_rd", q_rd.size(), 32'd0);
        check_eq("abort_mem", mem[2], ref_mem[2]);
        do_op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 0, 0);

        // Word store that wraps to index 0 with req held high throughout.
        for (int i = 0; i < 3; i++)
            do_op(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D + 32'(i), 1, 0);
        req = 1'b0;
        do_op(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 0, 0);
        check_eq("wrap_mem0", mem[0], 32'hCAFEF00F);

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_queues", q_done.size() + q_wr.size() + q_rd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
